// File: rtl/ddr_cmd_dispatch_if.sv
// Memory controller user (app_*) command and write-data port.
// Master drives commands/data, slave returns the ready handshakes.
interface ddr_cmd_dispatch_if #(
   parameter int ADX_W  = 27,
   parameter int DATA_W = 128
);
   logic              app_rdy;
   logic              app_wdf_rdy;
   logic              app_en;
   logic [2:0]        app_cmd;
   logic [ADX_W-1:0]  app_addr;
   logic              app_wdf_wren;
   logic              app_wdf_end;
   logic [DATA_W-1:0] app_wdf_data;
   logic [DATA_W/8-1:0] app_wdf_mask;

   modport master (
      input  app_rdy,
      input  app_wdf_rdy,
      output app_en,
      output app_cmd,
      output app_addr,
      output app_wdf_wren,
      output app_wdf_end,
      output app_wdf_data,
      output app_wdf_mask
   );

   modport slave (
      output app_rdy,
      output app_wdf_rdy,
      input  app_en,
      input  app_cmd,
      input  app_addr,
      input  app_wdf_wren,
      input  app_wdf_end,
      input  app_wdf_data,
      input  app_wdf_mask
   );
endinterface

// File: rtl/ddr_cmd_dispatch.sv
// Round-robin dispatcher from write/read request FIFOs to the
// controller app interface; writes go data beat first, then command.
module ddr_cmd_dispatch #(
   parameter int ADX_W  = 27,
   parameter int DATA_W = 128,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              init_calib_complete,
   input  logic              has_wr_adx,
   input  logic              has_wr_data,
   input  logic [ADX_W-1:0]  wr_adx_in,
   input  logic [DATA_W-1:0] wr_data_in,
   output logic              get_wr_adx,
   output logic              get_wr_data,
   input  logic              has_rd_adx,
   input  logic [ADX_W-1:0]  rd_adx_in,
   output logic              get_rd_adx,
   output logic              busy,
   output logic [CNT_W-1:0]  wr_issued,
   output logic [CNT_W-1:0]  rd_issued,
   ddr_cmd_dispatch_if.master app
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_DATA = 2'd1,
      WR_CMD  = 2'd2,
      RD_CMD  = 2'd3
   } state_t;

   state_t           state;
   logic             last_rd;
   logic [CNT_W-1:0] wr_cnt;
   logic [CNT_W-1:0] rd_cnt;

   logic wr_elig;
   logic rd_elig;
   logic pick_wr;
   logic pick_rd;

   // last_rd breaks ties: the side not served last wins contention
   assign wr_elig = has_wr_adx & has_wr_data;
   assign rd_elig = has_rd_adx;
   assign pick_wr = wr_elig & (~rd_elig | last_rd);
   assign pick_rd = rd_elig & (~wr_elig | ~last_rd);

   assign busy      = (state != IDLE);
   assign wr_issued = wr_cnt;
   assign rd_issued = rd_cnt;

   // Sequencer: arbitrate in IDLE, hold each strobe until accepted
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         last_rd <= 1'b1;
         wr_cnt  <= '0;
         rd_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (init_calib_complete) begin
                  unique case (1'b1)
                     pick_wr: begin
                        state   <= WR_DATA;
                        last_rd <= 1'b0;
                     end
                     pick_rd: begin
                        state   <= RD_CMD;
                        last_rd <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            WR_DATA: begin
               if (app.app_wdf_rdy)
                  state <= WR_CMD;
            end
            WR_CMD: begin
               if (app.app_rdy) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  state  <= IDLE;
               end
            end
            RD_CMD: begin
               if (app.app_rdy) begin
                  rd_cnt <= rd_cnt + 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes and payload decoded from state; payload zero when idle
   always_comb begin
      app.app_en       = 1'b0;
      app.app_cmd      = 3'b000;
      app.app_addr     = '0;
      app.app_wdf_wren = 1'b0;
      app.app_wdf_end  = 1'b0;
      app.app_wdf_data = '0;
      app.app_wdf_mask = '0;
      get_wr_adx       = 1'b0;
      get_wr_data      = 1'b0;
      get_rd_adx       = 1'b0;
      case (state)
         WR_DATA: begin
            app.app_wdf_wren = 1'b1;
            app.app_wdf_end  = 1'b1;
            app.app_wdf_data = wr_data_in;
            get_wr_data      = app.app_wdf_rdy;
         end
         WR_CMD: begin
            app.app_en   = 1'b1;
            app.app_cmd  = 3'b000;
            app.app_addr = wr_adx_in;
            get_wr_adx   = app.app_rdy;
         end
         RD_CMD: begin
            app.app_en   = 1'b1;
            app.app_cmd  = 3'b001;
            app.app_addr = rd_adx_in;
            get_rd_adx   = app.app_rdy;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/ddr_cmd_dispatch.md
Name: ddr_cmd_dispatch

Overview:
Command dispatcher between the DDR write/read request FIFOs and the memory controller user (app_*) interface.
- Arbitrates round-robin between pending writes (address and data FIFOs) and pending reads (read address FIFO).
- Sequences each write as one data beat followed by one command, and issues reads as single commands.
- Pops the source FIFOs only on an accepted handshake.
- Keeps wrapping issue counters for debug.

Parameters:
ADX_W, 27, address width of FIFO heads and app_addr
DATA_W, 128, write data width
CNT_W, 16, width of wr_issued/rd_issued counters

Ports:
clk  in  1  system clock
resetn  in  1  reset; one clock; reset is asynchronous and active-low
init_calib_complete  in  1  controller calibrated; no arbitration while low
has_wr_adx  in  1  write address FIFO non-empty (FWFT head valid)
has_wr_data  in  1  write data FIFO non-empty (FWFT head valid)
wr_adx_in  in  ADX_W  write address FIFO head
wr_data_in  in  DATA_W  write data FIFO head
get_wr_adx  out  1  pop write address FIFO
get_wr_data  out  1  pop write data FIFO
has_rd_adx  in  1  read address FIFO non-empty
rd_adx_in  in  ADX_W  read address FIFO head
get_rd_adx  out  1  pop read address FIFO
app_rdy  in  1  controller accepts command
app_wdf_rdy  in  1  controller accepts write data
app_en  out  1  command valid
app_cmd  out  3  3'b000 write, 3'b001 read
app_addr  out  ADX_W  command address
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  last beat; equals app_wdf_wren (single-beat bursts)
app_wdf_data  out  DATA_W  write data
app_wdf_mask  out  DATA_W/8  constant 0
busy  out  1  state != IDLE
wr_issued  out  CNT_W  accepted write commands, wraps
rd_issued  out  CNT_W  accepted read commands, wraps

Behaviour:
- Reset (async, resetn low): state=IDLE, last_grant=READ (so the first contention goes to write), counters=0. All strobes (app_en, app_wdf_wren, get_*) and busy are 0 immediately. Entries not yet popped stay in their FIFOs.
- Strobes are combinational from the state register and the FIFO heads. app_addr, app_wdf_data and app_cmd are held at 0 outside their active states.
- IDLE:
  - Nothing happens unless init_calib_complete=1.
  - wr_elig = has_wr_adx & has_wr_data; rd_elig = has_rd_adx.
  - If both are eligible, grant the side opposite last_grant. Otherwise grant the eligible side.
  - Next state is WR_DATA or RD_CMD, and last_grant is updated.
- WR_DATA:
  - app_wdf_wren=app_wdf_end=1, app_wdf_data=wr_data_in.
  - get_wr_data = app_wdf_rdy.
  - On app_wdf_rdy go to WR_CMD; otherwise hold with the data stable.
- WR_CMD:
  - app_en=1, app_cmd=000, app_addr=wr_adx_in.
  - get_wr_adx = app_rdy.
  - On app_rdy: wr_issued+1, go to IDLE.
- RD_CMD:
  - app_en=1, app_cmd=001, app_addr=rd_adx_in.
  - get_rd_adx = app_rdy.
  - On app_rdy: rd_issued+1, go to IDLE.
- Handshake rules:
  - A pop occurs exactly in the cycle of acceptance, never otherwise; there is at most one pop per FIFO per cycle.
  - Once app_en or app_wdf_wren is asserted, it stays high with stable payload until accepted.
- init_calib_complete dropping mid-transaction does not abort; the current transaction completes, then the block holds in IDLE.
- Latency: minimum 3 cycles per write (IDLE, WR_DATA, WR_CMD), 2 per read. A request present in IDLE at edge N shows its strobe in cycle N+1.
- Counters wrap from 2^CNT_W-1 to 0.
- Illegal state encoding recovers to IDLE.

Test Plan:
1. Reset asserted mid-WR_CMD with app_rdy=0 -> app_en and busy drop to 0 the same cycle; wr_issued=0; no get_* pulse.
2. One write (adx 27'h0000100, data 128'hA5..A5), app_rdy=app_wdf_rdy=1 -> app_wdf_wren in cycle 1 with get_wr_data, app_en/cmd=000/addr=0x100 in cycle 2 with get_wr_adx; wr_issued=1.
3. Write and read both pending for 6 requests each, ready always 1 -> grant order W,R,W,R...; wr_issued=rd_issued=6; no back-to-back same-side grants while both are eligible.
4. app_rdy held 0 for 5 cycles during RD_CMD -> app_en and app_addr stable for 5 cycles, get_rd_adx pulses exactly once on acceptance.
5. has_wr_adx=1, has_wr_data=0 -> no write granted; a pending read is still served; the write is granted once data arrives.
6. init_calib_complete=0 with all FIFOs non-empty -> busy=0, no strobes; asserting it yields a write grant on the next cycle. Also preload wr_issued=16'hFFFF and issue one write -> wraps to 0.
